lvl1_stream_checker: RTL and testbench
======================================

Name: lvl1_stream_checker

Overview:
- Receive-side checker for the scan-inject test target's 1-bit output stream (the AND of bit 1 of two free-running 8-bit add-counters).
- Holds a golden model of both counters, aligns to the target's reset through a sync strobe, and compares every received bit against the expected bit.
- Reports a sticky error flag, an error count, the first failing index and a done flag; used to detect state corruption injected through the scan chain.

Parameters:
- WIDTH, 8, counter width of the golden model.
- SEED_A, 8'hDE, load value of model counter A.
- INC_A, 8'h09, per-cycle increment of counter A.
- SEED_B, 8'hBE, load value of model counter B.
- INC_B, 8'h0B, per-cycle increment of counter B.
- TAP, 1, bit index of each counter that is ANDed to form the expected bit.
- CHECK_LEN, 256, number of bits compared per run (must be 1 to 2^CNT_W-1).
- CNT_W, 16, width of the index and error counters.
- STOP_ON_ERR, 0, 1 = halt the run at the first mismatch.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low; asserting it forces the reset state immediately.
- sync  in  1  asserted in the same cycle the target's reset is high; aligns the model.
- din  in  1  observed target output bit, sampled every clk.
- busy  out  1  high while in CHECK.
- done  out  1  run finished (level, held until next sync).
- err  out  1  sticky: at least one mismatch this run.
- err_cnt  out  CNT_W  mismatch count, saturating at all-ones.
- first_err_idx  out  CNT_W  index of the first mismatch; 0 when err=0.
- bit_idx  out  CNT_W  number of bits compared so far this run.

Behaviour:
- Reset (rst=0): state IDLE; model A=0, B=0; all outputs 0. Reset may occur mid-run; the run is abandoned and no partial result is retained.
- States: IDLE, CHECK, DONE, FAIL.
- Sync: sync=1 in any state loads A<=SEED_A and B<=SEED_B on that edge, clears bit_idx, err, err_cnt, first_err_idx and done, and sets state<=CHECK. Sync has priority over every other transition. din is not compared in the sync cycle.
- CHECK, each cycle:
  - exp = A[TAP] & B[TAP].
  - A<=A+INC_A and B<=B+INC_B, both modulo 2^WIDTH (wrap, no carry out).
  - bit_idx<=bit_idx+1.
  - On mismatch (din!=exp): err<=1 and err_cnt<=err_cnt+1, saturating. If err was 0, first_err_idx<=bit_idx (pre-increment value).
- Latency: the first bit compared is the one sampled in the cycle after sync, matching the target's first post-reset output. Flags reflect a compare one edge after the compared bit is sampled.
- Run completion, checked in this order:
  - Mismatch with STOP_ON_ERR=1: go to FAIL; done=1 on that edge.
  - Otherwise, when the compare at bit_idx==CHECK_LEN-1 completes: go to DONE; done=1 on that edge.
- DONE and FAIL: model and counters frozen, din ignored, exit only via sync or rst.
- IDLE: din ignored, model frozen.
- busy = (state==CHECK).
- Combined event: a mismatch on the final bit sets err/err_cnt and done on the same edge.

Test Plan:
- Reset, then sync, then drive din = golden sequence 1,0,0,0,... (A: DE,E7,F0,F9; B: BE,C9,D4,DF) for 256 bits -> done=1 after the 256th compare, err=0, err_cnt=0, bit_idx=256, busy low.
- Same run with din inverted at bit indices 5 and 9 -> err=1, err_cnt=2, first_err_idx=5, done=1.
- STOP_ON_ERR=1, din wrong at index 3 -> FAIL entered, done=1, bit_idx=4, err_cnt=1; later din toggling changes nothing.
- din stuck at 0 for the full run -> err_cnt equals the number of 1s in the golden 256-bit sequence, first_err_idx=0.
- rst pulsed low at bit 100 -> all outputs 0 immediately and IDLE. A second sync mid-run at bit 50 -> counters cleared, compare restarts at index 0.
- CNT_W=4 with constant mismatch over CHECK_LEN=15 -> err_cnt saturates at 15 (no wrap), done=1.

Source files
------------

// File: rtl/lvl1_stream_checker_if.sv
// Handshake bundle between the stream checker and whatever drives/observes it.
// The master side drives sync/din and reads results; the checker is the slave.
interface lvl1_stream_checker_if #(
    parameter int CNT_W = 16
);
    logic             sync;
    logic             din;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_idx;
    logic [CNT_W-1:0] bit_idx;

    modport master (
        output sync, din,
        input  busy, done, err, err_cnt, first_err_idx, bit_idx
    );

    modport slave (
        input  sync, din,
        output busy, done, err, err_cnt, first_err_idx, bit_idx
    );
endinterface

// File: rtl/lvl1_stream_checker.sv
// Golden-model checker for the 1-bit stream produced by two free-running add-counters.
// Aligns on sync, compares one bit per cycle and reports error statistics.
//
// state   | meaning
// S_IDLE  | after reset, waiting for the first sync; din ignored
// S_CHECK | comparing din against the golden bit every cycle
// S_DONE  | CHECK_LEN bits compared; results frozen until sync
// S_FAIL  | stopped on first mismatch (STOP_ON_ERR); results frozen until sync
module lvl1_stream_checker #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SEED_A      = 8'hDE,
    parameter logic [WIDTH-1:0] INC_A       = 8'h09,
    parameter logic [WIDTH-1:0] SEED_B      = 8'hBE,
    parameter logic [WIDTH-1:0] INC_B       = 8'h0B,
    parameter int               TAP         = 1,
    parameter int               CHECK_LEN   = 256,
    parameter int               CNT_W       = 16,
    parameter bit               STOP_ON_ERR = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    lvl1_stream_checker_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHECK_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_bit_idx;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_first_idx;
    logic             r_err;
    logic             w_exp;
    logic             w_mismatch;

    assign w_exp      = r_a[TAP] & r_b[TAP];
    assign w_mismatch = (r_state == S_CHECK) && (bus.din != w_exp);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // sync outranks every other transition, including leaving DONE/FAIL
    always_comb begin
        w_state_nxt = r_state;
        if (bus.sync) begin
            w_state_nxt = S_CHECK;
        end else if (r_state == S_CHECK) begin
            if (w_mismatch && STOP_ON_ERR) begin
                w_state_nxt = S_FAIL;
            end else if (r_bit_idx == LAST_IDX) begin
                w_state_nxt = S_DONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_bit_idx   <= '0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_err       <= 1'b0;
        end else if (bus.sync) begin
            r_a         <= SEED_A;
            r_b         <= SEED_B;
            r_bit_idx   <= '0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_err       <= 1'b0;
        end else if (r_state == S_CHECK) begin
            r_a       <= r_a + INC_A;
            r_b       <= r_b + INC_B;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (w_mismatch) begin
                r_err <= 1'b1;
                if (r_err_cnt != CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (!r_err) begin
                    r_first_idx <= r_bit_idx;
                end
            end
        end
    end

    assign bus.busy          = (r_state == S_CHECK);
    assign bus.done          = (r_state == S_DONE) || (r_state == S_FAIL);
    assign bus.err           = r_err;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.first_err_idx = r_first_idx;
    assign bus.bit_idx       = r_bit_idx;

endmodule

// File: tb/tb_lvl1_stream_checker.sv
// Bench for lvl1_stream_checker: three instances (default, stop-on-error, 4-bit counters)
// share one stimulus stream and are checked every cycle against a closed-form model.
module tb_lvl1_stream_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sync  = 1'b0;
    logic din   = 1'b0;

    always #5 clk = ~clk;

    lvl1_stream_checker_if #(.CNT_W(16)) if0 ();
    lvl1_stream_checker_if #(.CNT_W(16)) if1 ();
    lvl1_stream_checker_if #(.CNT_W(4))  if2 ();

    assign if0.sync = sync;
    assign if0.din  = din;
    assign if1.sync = sync;
    assign if1.din  = din;
    assign if2.sync = sync;
    assign if2.din  = din;

    lvl1_stream_checker #(.CNT_W(16), .CHECK_LEN(256), .STOP_ON_ERR(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave));
    lvl1_stream_checker #(.CNT_W(16), .CHECK_LEN(256), .STOP_ON_ERR(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));
    lvl1_stream_checker #(.CNT_W(4), .CHECK_LEN(15), .STOP_ON_ERR(1'b0)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if2.slave));

    logic        o_busy [3];
    logic        o_done [3];
    logic        o_err  [3];
    logic [15:0] o_cnt  [3];
    logic [15:0] o_first[3];
    logic [15:0] o_idx  [3];

    assign o_busy[0] = if0.busy;  assign o_busy[1] = if1.busy;  assign o_busy[2] = if2.busy;
    assign o_done[0] = if0.done;  assign o_done[1] = if1.done;  assign o_done[2] = if2.done;
    assign o_err[0]  = if0.err;   assign o_err[1]  = if1.err;   assign o_err[2]  = if2.err;
    assign o_cnt[0]   = if0.err_cnt;       assign o_cnt[1]   = if1.err_cnt;
    assign o_cnt[2]   = {12'd0, if2.err_cnt};
    assign o_first[0] = if0.first_err_idx; assign o_first[1] = if1.first_err_idx;
    assign o_first[2] = {12'd0, if2.first_err_idx};
    assign o_idx[0]   = if0.bit_idx;       assign o_idx[1]   = if1.bit_idx;
    assign o_idx[2]   = {12'd0, if2.bit_idx};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int d, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    // expected bit k straight from the counter definitions: seed + k*inc, bit 1 of each
    function automatic bit gold(input int k);
        int a;
        int b;
        a = (8'hDE + k * 9) % 256;
        b = (8'hBE + k * 11) % 256;
        return a[1] & b[1];
    endfunction

    // model: phase 0 = idle, 1 = checking, 2 = finished (done or failed)
    int p_len [3] = '{256, 256, 15};
    int p_stop[3] = '{0, 1, 0};
    int p_max [3] = '{65535, 65535, 15};
    int m_phase[3];
    int m_k    [3];
    int m_cnt  [3];
    int m_first[3];
    int m_err  [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_phase[d] = 0; m_k[d] = 0; m_cnt[d] = 0; m_first[d] = 0; m_err[d] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (sync) begin
                    m_phase[d] = 1; m_k[d] = 0; m_cnt[d] = 0; m_first[d] = 0; m_err[d] = 0;
                end else if (m_phase[d] == 1) begin
                    bit mis;
                    mis = (din != gold(m_k[d]));
                    if (mis) begin
                        if (m_cnt[d] < p_max[d]) m_cnt[d] = m_cnt[d] + 1;
                        if (m_err[d] == 0) m_first[d] = m_k[d];
                        m_err[d] = 1;
                    end
                    m_k[d] = m_k[d] + 1;
                    if (mis && p_stop[d] != 0) m_phase[d] = 2;
                    else if (m_k[d] == p_len[d]) m_phase[d] = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                chk("busy",          d, longint'(o_busy[d]),  longint'(m_phase[d] == 1));
                chk("done",          d, longint'(o_done[d]),  longint'(m_phase[d] == 2));
                chk("err",           d, longint'(o_err[d]),   longint'(m_err[d]));
                chk("err_cnt",       d, longint'(o_cnt[d]),   longint'(m_cnt[d]));
                chk("first_err_idx", d, longint'(o_first[d]), longint'(m_first[d]));
                chk("bit_idx",       d, longint'(o_idx[d]),   longint'(m_k[d] & p_max[d]));
            end
        end
    end

    // mode 0: golden with flips at fa/fb, 1: stuck at 0, 2: every bit inverted
    task automatic run(input int n, input int mode, input int fa, input int fb);
        @(negedge clk);
        sync = 1'b1;
        din  = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sync = 1'b0;
            case (mode)
                1:       din = 1'b0;
                2:       din = ~gold(k);
                default: din = gold(k) ^ ((k == fa) || (k == fb));
            endcase
        end
        @(negedge clk);
        din = 1'b0;
    endtask

    int ones;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, longint'(if0.busy),    0);
        chk("rst_done", 0, longint'(if0.done),    0);
        chk("rst_cnt",  0, longint'(if0.err_cnt), 0);
        chk("rst_idx",  0, longint'(if0.bit_idx), 0);
        rst_n = 1'b1;

        // pins the model's golden sequence start: 1,0,0,0
        chk("gold0", 0, longint'(gold(0)), 1);
        chk("gold1", 0, longint'(gold(1)), 0);
        chk("gold3", 0, longint'(gold(3)), 0);

        run(256, 0, -1, -1);
        chk("clean_done", 0, longint'(if0.done),    1);
        chk("clean_err",  0, longint'(if0.err),     0);
        chk("clean_idx",  0, longint'(if0.bit_idx), 256);
        chk("clean_busy", 0, longint'(if0.busy),    0);
        chk("short_idx",  2, longint'(if2.bit_idx), 15);

        run(256, 0, 5, 9);
        chk("two_err",   0, longint'(if0.err),           1);
        chk("two_cnt",   0, longint'(if0.err_cnt),       2);
        chk("two_first", 0, longint'(if0.first_err_idx), 5);
        chk("two_done",  0, longint'(if0.done),          1);

        run(256, 0, 3, -1);
        chk("stop_done", 1, longint'(if1.done),    1);
        chk("stop_idx",  1, longint'(if1.bit_idx), 4);
        chk("stop_cnt",  1, longint'(if1.err_cnt), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            din = ~din;
        end
        chk("stop_hold_idx", 1, longint'(if1.bit_idx), 4);
        chk("stop_hold_cnt", 1, longint'(if1.err_cnt), 1);

        run(256, 1, -1, -1);
        ones = 0;
        for (int k = 0; k < 256; k++) ones += int'(gold(k));
        chk("stuck_cnt",   0, longint'(if0.err_cnt),       ones);
        chk("stuck_first", 0, longint'(if0.first_err_idx), 0);

        run(256, 2, -1, -1);
        chk("sat_cnt",  2, longint'(if2.err_cnt), 15);
        chk("sat_done", 2, longint'(if2.done),    1);
        chk("inv_cnt",  0, longint'(if0.err_cnt), 256);

        run(100, 0, 20, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_err",  0, longint'(if0.err),     0);
        chk("midrst_cnt",  0, longint'(if0.err_cnt), 0);
        chk("midrst_idx",  0, longint'(if0.bit_idx), 0);
        chk("midrst_busy", 0, longint'(if0.busy),    0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_idle", 0, longint'(if0.busy), 0);

        run(50, 0, 10, -1);
        run(256, 0, -1, -1);
        chk("resync_err", 0, longint'(if0.err),     0);
        chk("resync_idx", 0, longint'(if0.bit_idx), 256);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
